// File: rtl/mux_rr_arbiter_4x1.sv
// mux_rr_arbiter_4x1: round-robin owner selection for a shared 4:1 word path.
// One requester owns the path at a time; each beat registers the owner's word
// with a one-cycle valid strobe. The rotating pointer puts the previous owner
// last on every release.
// Optional feature: define MUX_ARB_BURST_LIMIT_EN to force a release after
// MAX_BURST beats. Without it, an owner keeps the path until it drops req.
module mux_rr_arbiter_4x1 #(
    parameter int N         = 3,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [N-1:0] w0,
    input  logic [N-1:0] w1,
    input  logic [N-1:0] w2,
    input  logic [N-1:0] w3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [N-1:0] f,
    output logic         f_valid
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t       r_state;
    logic [1:0]   r_ptr;

    logic [N-1:0] w_word;
    logic         w_beat;
    logic         w_release;
    logic [1:0]   w_arb_base;
    logic         w_found;
    logic [1:0]   w_win;

    // Mux the current owner's word onto the shared path
    always_comb begin
        w_word = w0;
        case (sel)
            2'd0:    w_word = w0;
            2'd1:    w_word = w1;
            2'd2:    w_word = w2;
            default: w_word = w3;
        endcase
    end

    assign w_beat = (r_state == S_GRANT) && req[sel];

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    // The beat that brings the count to MAX_BURST is the last one of the grant
    assign w_last    = w_beat && (r_cnt == CW'(MAX_BURST - 1));
    assign w_release = (r_state == S_GRANT) && (!req[sel] || w_last);
`else
    logic w_unused_cfg;

    // No burst limit: the owner keeps the path until it drops its request
    assign w_release    = (r_state == S_GRANT) && !req[sel];
    assign w_unused_cfg = ^MAX_BURST;
`endif

    // On release the search starts just past the old owner, so it ends up last
    assign w_arb_base = (r_state == S_IDLE) ? r_ptr : (sel + 2'd1);

    // First requester in search order starting at w_arb_base
    always_comb begin
        logic [1:0] v_idx;
        w_found = 1'b0;
        w_win   = w_arb_base;
        v_idx   = w_arb_base;
        for (int k = 3; k >= 0; k--) begin
            v_idx = w_arb_base + 2'(k);
            if (req[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    // Owner FSM with registered grant, select and data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            gnt     <= 4'b0000;
            sel     <= 2'd0;
            f       <= '0;
            f_valid <= 1'b0;
`ifdef MUX_ARB_BURST_LIMIT_EN
            r_cnt   <= '0;
`endif
        end else begin
            f_valid <= w_beat;
            if (w_beat) begin
                f <= w_word;
            end
`ifdef MUX_ARB_BURST_LIMIT_EN
            // Saturating beat count; a new grant below clears it
            if (w_beat && (r_cnt != CW'(MAX_BURST))) begin
                r_cnt <= r_cnt + 1'b1;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        gnt     <= 4'b0001 << w_win;
                        sel     <= w_win;
                        r_state <= S_GRANT;
`ifdef MUX_ARB_BURST_LIMIT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_ptr <= sel + 2'd1;
                        if (w_found) begin
                            // Direct handover, no idle cycle in between
                            gnt   <= 4'b0001 << w_win;
                            sel   <= w_win;
`ifdef MUX_ARB_BURST_LIMIT_EN
                            r_cnt <= '0;
`endif
                        end else begin
                            gnt     <= 4'b0000;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mux_rr_arbiter_4x1.md
# mux_rr_arbiter_4x1

Round-robin arbiter that shares one N-bit 4:1 select path among four requesters. It picks the owner, drives the 2-bit select and a one-hot grant, and registers the selected word with a valid strobe. The block sits in front of the shared bus or consumer, so a consumer sees a single stream of words with at most one source active at a time.

## Interface
- N, default 3: data width of each requester word and of the output word.
- MAX_BURST, default 4: maximum beats per grant when the burst limit is compiled in; must be ≥1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i belongs to requester i.
- w0, w1, w2, w3  input  N each  data words of requesters 0..3.
- gnt  output  4  registered one-hot grant; all zeros when idle.
- sel  output  2  registered index of the current owner; holds its last value when idle.
- f  output  N  registered selected word.
- f_valid  output  1  registered; high for one cycle per transferred beat.

## Operation
- State machine with two states, IDLE and GRANT.
- A 2-bit priority pointer `ptr` marks the highest-priority requester. Search order is ptr, ptr+1, ptr+2, ptr+3, taken mod 4.
- Beat: any cycle in GRANT with req[sel]=1. One beat loads f<=w[sel] and f_valid<=1. In every other cycle f_valid<=0 and f holds its value.
- IDLE:
  - If req≠0, grant the first requester in search order. Set gnt one-hot, set sel, clear the beat count, and go to GRANT.
  - If req=0, stay in IDLE.
- GRANT, release conditions:
  - req[sel]=0, which is not a beat.
  - The burst limit is reached, as described in Configuration.
- GRANT, on release:
  - Set ptr<=sel+1 (mod 4).
  - Re-arbitrate in the same cycle, using search order from the new ptr over the current req. The previous owner is eligible only if it is still requesting, and it then has lowest priority.
  - If a winner exists, grant it directly with no idle cycle and clear the beat count. Otherwise gnt<=0 and go to IDLE.
- The beat count has width $clog2(MAX_BURST+1) and saturates. It never wraps.
- Simultaneous events:
  - A request rising in the same cycle as a release is included in that re-arbitration.
  - Requests from non-owners during GRANT are ignored until release.
- Data words are sampled only on beats. Non-owner words are don't-care.

## Timing
- Reset values: state IDLE, ptr=0, gnt=4'b0000, sel=2'b00, f=0, f_valid=0, beat count 0.
- Reset asserted in any state, including mid-burst, takes effect at that edge. f_valid is low in the next cycle and no partial burst resumes.
- Request to grant: req rises in cycle t while IDLE → gnt/sel valid in cycle t+1.
- Grant to data: the first beat is cycle t+1 → f/f_valid visible in cycle t+2.
- Handover on req drop: the owner drops req in cycle k → the new gnt is visible in cycle k+1. There is one gap cycle with f_valid=0 in cycle k+1.
- Handover on burst limit: the last beat is in cycle k → the new gnt is visible in cycle k+1. f_valid is continuous if the next owner is requesting.
- Throughput: one beat per cycle while the owner holds req.

## Configuration
- MUX_ARB_BURST_LIMIT_EN defined:
  - A grant releases after the beat that brings the count to MAX_BURST.
  - A sole requester still requesting is re-granted immediately with the count cleared, with no gap.
- MUX_ARB_BURST_LIMIT_EN undefined:
  - No beat counter logic.
  - A grant is held until req[sel]=0, so the owner may hold the path indefinitely.
  - MAX_BURST is unused.

## Test plan
- Reset, then req=4'b0100 held with w2=3'h5 → gnt=4'b0100 and sel=2 at cycle 1. f=5 and f_valid=1 from cycle 2 onward. With the macro defined, f_valid stays continuous across re-grants.
- req=4'b1111 held, macro defined, MAX_BURST=4 → owners 0,1,2,3,0 in turn, each for exactly 4 beats. f_valid never drops after the first beat.
- Owner 1 drops req after 2 beats with req[3]=1, req[0]=1 → the next grant is requester 3, because ptr=2. There is exactly one f_valid=0 cycle.
- rst pulsed for one cycle mid-burst of owner 2 → next cycle gnt=0, f_valid=0, f=0, ptr=0. After that, req=4'b1100 grants requester 2 first.
- Macro undefined, req=4'b0011 held for 20 cycles → requester 0 owns all 20 beats. Dropping req[0] hands over to requester 1 after one gap cycle.
- req=0 throughout → the block stays IDLE with gnt=0 and f_valid=0 for 50 cycles.
